cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multicycle main control unit for the CPU datapath.
- Consumes opcode, funct and ALU flags from the datapath.
- Produces every write-enable and mux-select control wire the datapath expects.
- Moore FSM with one Mealy term (branch PC write). Supports add/sub/and, addi, lw, sw, beq, bne, j, break, and overflow/invalid-opcode exceptions.

Parameters:
MEM_WAIT, 1, extra wait cycles after any memory read before read data is valid (0..3)
OVF_VECTOR, 8'd255, memory byte address holding the overflow handler address
OPC_VECTOR, 8'd254, memory byte address holding the invalid-opcode handler address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0] (immediate[5:0])
Of  in  1  ALU overflow
Eq  in  1  ALU equal flag
PC_w  out  1  PC write enable
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR write enable
RegWrite  out  1  register bank write
ABWrite  out  1  A/B register write
ALUoutWrite  out  1  ALUout register write
EPCWrite  out  1  EPC write
CtrlALUSrcA  out  2  0=PC, 1=A
CtrlALUSrcB  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
CtrlIord  out  3  0=PC, 1=ALUout, 2=OPC_VECTOR, 3=OVF_VECTOR
CtrlRegDst  out  3  0=rt, 1=rd
CtrlMemtoReg  out  4  0=ALUout, 1=MDR
CtrlPCSource  out  3  0=ALU_result, 1=ALUout, 2=jump target, 4=MDR byte zero-ext
CtrlULA  out  3  001 add, 010 sub, 011 and, 111 compare
state_dbg  out  5  current state encoding

Behaviour:
- Async reset: state RESET; all enables 0 and all selects 0 immediately, irrespective of clk. First edge after release enters FETCH.
- Reset mid-operation aborts with no further writes.
- Outputs are decoded from state only, except PC_w in BRANCH. Unlisted outputs are 0 in each state.
- Wait counter: 2 bits, cleared on every state change.
- FETCH: MemRead=1, Iord=0. Held MEM_WAIT+1 cycles.
  - In the last cycle only: IRWrite=1, PC_w=1, SrcA=0, SrcB=1, ULA=add, PCSource=0.
  - Next state: DECODE.
- DECODE (1 cycle): ABWrite=1, ALUoutWrite=1, SrcA=0, SrcB=3, ULA=add (branch target). Dispatch on opcode:
  - 0x00: funct 0x20/0x22/0x24 -> EXEC_R; 0x0d -> HALT; else -> EXC_OPC.
  - 0x08 -> EXEC_I; 0x23 -> ADDR_LW; 0x2b -> ADDR_SW; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; else -> EXC_OPC.
- EXEC_R: SrcA=1, SrcB=0, ULA from funct (add/sub/and), ALUoutWrite=1.
  - Of=1 with add/sub -> EXC_OVF (Of ignored for and); else -> WB_R.
- WB_R: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- EXEC_I: SrcA=1, SrcB=2, add, ALUoutWrite=1. Of -> EXC_OVF; else -> WB_I.
- WB_I: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- ADDR_LW / ADDR_SW: SrcA=1, SrcB=2, add, ALUoutWrite=1 -> MEM_RD / MEM_WR.
- MEM_RD: Iord=1, MemRead=1, held MEM_WAIT+1 cycles -> WB_LW.
- WB_LW: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEM_WR: Iord=1, MemWrite=1, exactly 1 cycle -> FETCH.
- BRANCH: SrcA=1, SrcB=0, ULA=compare, PCSource=1.
  - PC_w = (opcode==0x04 & Eq) | (opcode==0x05 & ~Eq).
  - Next state: FETCH.
- JUMP: PCSource=2, PC_w=1 -> FETCH.
- EXC_OVF / EXC_OPC (1 cycle): SrcA=0, SrcB=1, ULA=sub, EPCWrite=1 (EPC = PC-4) -> EXC_RD.
  - The exception cause is latched in a 1-bit register.
- EXC_RD: MemRead=1, Iord=3 (overflow) or 2 (opcode), held MEM_WAIT+1 cycles -> EXC_PC.
- EXC_PC: PCSource=4, PC_w=1 -> FETCH.
- Exception paths never assert RegWrite. The destination register is unchanged on overflow.
- HALT: all outputs 0; remains until reset.
- Never assert MemRead and MemWrite in the same cycle, nor IRWrite outside FETCH.

Test Plan:
- Reset low mid-EXEC_R -> outputs 0 immediately, state_dbg=RESET; release -> FETCH with MemRead=1, Iord=0.
- MEM_WAIT=1, opcode=0, funct=0x20, Of=0 -> FETCH 2 cycles, DECODE, EXEC_R (ULA=001), WB_R (RegWrite=1, RegDst=1); back in FETCH 5 cycles after start.
- opcode=0x04 with Eq=1 -> BRANCH asserts PC_w=1, PCSource=1; repeat with Eq=0 -> PC_w=0; opcode=0x05 with Eq=0 -> PC_w=1.
- opcode=0x23 -> ADDR_LW (SrcB=2), MEM_RD held 2 cycles with Iord=1, WB_LW (MemtoReg=1, RegWrite=1); opcode=0x2b -> single MemWrite=1 cycle, RegWrite never 1.
- opcode=0x08 with Of=1 in EXEC_I -> EXC_OVF (EPCWrite=1, ULA=010), EXC_RD Iord=3, EXC_PC PC_w=1, PCSource=4; no RegWrite throughout.
- opcode=0x3f -> EXC_OPC then Iord=2; opcode=0, funct=0x0d -> HALT, outputs 0 for 20 cycles until reset.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multicycle control unit and the datapath:
// instruction fields and ALU flags in, write enables and mux selects out.
interface cpu_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Of;
  logic       Eq;
  logic       PC_w;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ABWrite;
  logic       ALUoutWrite;
  logic       EPCWrite;
  logic [1:0] CtrlALUSrcA;
  logic [1:0] CtrlALUSrcB;
  logic [2:0] CtrlIord;
  logic [2:0] CtrlRegDst;
  logic [3:0] CtrlMemtoReg;
  logic [2:0] CtrlPCSource;
  logic [2:0] CtrlULA;

  // master is the control unit, slave is the datapath
  modport master (
    input  opcode, funct, Of, Eq,
    output PC_w, MemRead, MemWrite, IRWrite, RegWrite, ABWrite, ALUoutWrite,
           EPCWrite, CtrlALUSrcA, CtrlALUSrcB, CtrlIord, CtrlRegDst,
           CtrlMemtoReg, CtrlPCSource, CtrlULA
  );
  modport slave (
    output opcode, funct, Of, Eq,
    input  PC_w, MemRead, MemWrite, IRWrite, RegWrite, ABWrite, ALUoutWrite,
           EPCWrite, CtrlALUSrcA, CtrlALUSrcB, CtrlIord, CtrlRegDst,
           CtrlMemtoReg, CtrlPCSource, CtrlULA
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle CPU main control: Moore FSM with registered control outputs,
// plus the single Mealy term that gates the PC write on branch outcome.
module cpu_control_fsm #(
  parameter int          MEM_WAIT   = 1,
  parameter logic [7:0]  OVF_VECTOR = 8'd255,
  parameter logic [7:0]  OPC_VECTOR = 8'd254
) (
  input  logic              clk,
  input  logic              reset,
  cpu_control_fsm_if.master bus,
  output logic [4:0]        state_dbg
);

  if (MEM_WAIT < 0 || MEM_WAIT > 3) begin : g_bad_wait
    $error("MEM_WAIT must be within 0..3");
  end
  if (OVF_VECTOR == OPC_VECTOR) begin : g_bad_vec
    $error("exception vectors must differ");
  end

  localparam logic [1:0] LAST = 2'(MEM_WAIT);

  typedef enum logic [4:0] {
    S_RESET = 5'd0,  S_FETCH = 5'd1,   S_DECODE = 5'd2,  S_EXEC_R = 5'd3,
    S_WB_R = 5'd4,   S_EXEC_I = 5'd5,  S_WB_I = 5'd6,    S_ADDR_LW = 5'd7,
    S_ADDR_SW = 5'd8, S_MEM_RD = 5'd9, S_WB_LW = 5'd10,  S_MEM_WR = 5'd11,
    S_BRANCH = 5'd12, S_JUMP = 5'd13,  S_EXC_OVF = 5'd14, S_EXC_OPC = 5'd15,
    S_EXC_RD = 5'd16, S_EXC_PC = 5'd17, S_HALT = 5'd18
  } state_t;

  typedef struct packed {
    logic       pc_w;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       aluout_write;
    logic       epc_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] iord;
    logic [2:0] reg_dst;
    logic [3:0] mem_to_reg;
    logic [2:0] pc_source;
    logic [2:0] ula;
  } ctrl_t;

  function automatic state_t next_state(state_t s, logic [1:0] cnt,
                                        logic [5:0] op, logic [5:0] fn, logic of);
    state_t n;
    case (s)
      S_RESET:   n = S_FETCH;
      S_FETCH:   n = (cnt == LAST) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          6'h00: begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) n = S_EXEC_R;
            else if (fn == 6'h0d)                          n = S_HALT;
            else                                           n = S_EXC_OPC;
          end
          6'h08:         n = S_EXEC_I;
          6'h23:         n = S_ADDR_LW;
          6'h2b:         n = S_ADDR_SW;
          6'h04, 6'h05:  n = S_BRANCH;
          6'h02:         n = S_JUMP;
          default:       n = S_EXC_OPC;
        endcase
      end
      // 'and' cannot overflow, so Of is meaningless there
      S_EXEC_R:  n = (of && fn != 6'h24) ? S_EXC_OVF : S_WB_R;
      S_EXEC_I:  n = of ? S_EXC_OVF : S_WB_I;
      S_ADDR_LW: n = S_MEM_RD;
      S_ADDR_SW: n = S_MEM_WR;
      S_MEM_RD:  n = (cnt == LAST) ? S_WB_LW : S_MEM_RD;
      S_EXC_OVF, S_EXC_OPC: n = S_EXC_RD;
      S_EXC_RD:  n = (cnt == LAST) ? S_EXC_PC : S_EXC_RD;
      S_HALT:    n = S_HALT;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(state_t s, logic [1:0] cnt, logic cause_ovf,
                                   logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        if (cnt == LAST) begin
          c.ir_write = 1'b1;
          c.pc_w     = 1'b1;
          c.src_b    = 2'd1;
          c.ula      = 3'b001;
        end
      end
      S_DECODE: begin
        c.ab_write     = 1'b1;
        c.aluout_write = 1'b1;
        c.src_b        = 2'd3;
        c.ula          = 3'b001;
      end
      S_EXEC_R: begin
        c.src_a        = 2'd1;
        c.aluout_write = 1'b1;
        c.ula          = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
      end
      S_WB_R: begin
        c.reg_dst   = 3'd1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I, S_ADDR_LW, S_ADDR_SW: begin
        c.src_a        = 2'd1;
        c.src_b        = 2'd2;
        c.ula          = 3'b001;
        c.aluout_write = 1'b1;
      end
      S_WB_I:   c.reg_write = 1'b1;
      S_MEM_RD: begin
        c.iord     = 3'd1;
        c.mem_read = 1'b1;
      end
      S_WB_LW: begin
        c.mem_to_reg = 4'd1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.iord      = 3'd1;
        c.mem_write = 1'b1;
      end
      // PC_w here comes from the Mealy branch term, not the register
      S_BRANCH: begin
        c.src_a     = 2'd1;
        c.ula       = 3'b111;
        c.pc_source = 3'd1;
      end
      S_JUMP: begin
        c.pc_source = 3'd2;
        c.pc_w      = 1'b1;
      end
      S_EXC_OVF, S_EXC_OPC: begin
        c.src_b     = 2'd1;
        c.ula       = 3'b010;
        c.epc_write = 1'b1;
      end
      S_EXC_RD: begin
        c.mem_read = 1'b1;
        c.iord     = cause_ovf ? 3'd3 : 3'd2;
      end
      S_EXC_PC: begin
        c.pc_source = 3'd4;
        c.pc_w      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state;
  state_t     nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       cause_ovf;
  ctrl_t      ctl;
  logic       branch_take;

  assign nxt     = next_state(state, cnt, bus.opcode, bus.funct, bus.Of);
  assign cnt_nxt = (nxt != state) ? 2'd0 : cnt + 2'd1;

  // outputs are registered against the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RESET;
      cnt       <= 2'd0;
      cause_ovf <= 1'b0;
      ctl       <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (nxt == S_EXC_OVF)      cause_ovf <= 1'b1;
      else if (nxt == S_EXC_OPC) cause_ovf <= 1'b0;
      ctl   <= decode(nxt, cnt_nxt, cause_ovf, bus.funct);
    end
  end

  assign branch_take = (state == S_BRANCH) &&
                       ((bus.opcode == 6'h04 &&  bus.Eq) ||
                        (bus.opcode == 6'h05 && !bus.Eq));

  assign bus.PC_w         = ctl.pc_w | branch_take;
  assign bus.MemRead      = ctl.mem_read;
  assign bus.MemWrite     = ctl.mem_write;
  assign bus.IRWrite      = ctl.ir_write;
  assign bus.RegWrite     = ctl.reg_write;
  assign bus.ABWrite      = ctl.ab_write;
  assign bus.ALUoutWrite  = ctl.aluout_write;
  assign bus.EPCWrite     = ctl.epc_write;
  assign bus.CtrlALUSrcA  = ctl.src_a;
  assign bus.CtrlALUSrcB  = ctl.src_b;
  assign bus.CtrlIord     = ctl.iord;
  assign bus.CtrlRegDst   = ctl.reg_dst;
  assign bus.CtrlMemtoReg = ctl.mem_to_reg;
  assign bus.CtrlPCSource = ctl.pc_source;
  assign bus.CtrlULA      = ctl.ula;
  assign state_dbg        = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm (MEM_WAIT=1): walks each instruction
// class cycle by cycle against hand-computed control values.
module tb_cpu_control_fsm;
  logic       clk;
  logic       reset;
  logic [4:0] state_dbg;
  logic [27:0] ctl_vec;
  int n_vec = 0;
  int n_err = 0;

  cpu_control_fsm_if bus();

  cpu_control_fsm #(.MEM_WAIT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  assign ctl_vec = {bus.PC_w, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                    bus.ABWrite, bus.ALUoutWrite, bus.EPCWrite, bus.CtrlALUSrcA,
                    bus.CtrlALUSrcB, bus.CtrlIord, bus.CtrlRegDst, bus.CtrlMemtoReg,
                    bus.CtrlPCSource, bus.CtrlULA};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // invariants sampled every cycle out of reset
  always @(negedge clk) begin
    if (reset) begin
      check("mr_mw_excl", 32'(bus.MemRead & bus.MemWrite), 0);
      check("ir_only_fetch", 32'(bus.IRWrite & (state_dbg != 5'd1)), 0);
      check("exc_no_rw", 32'(bus.RegWrite & (state_dbg >= 5'd14 && state_dbg <= 5'd17)), 0);
    end
  end

  // entered in FETCH cycle 0, leaves in DECODE
  task automatic do_fetch(input string id);
    check({id, "_f0_st"}, 32'(state_dbg), 1);
    check({id, "_f0_mr"}, 32'(bus.MemRead), 1);
    check({id, "_f0_iord"}, 32'(bus.CtrlIord), 0);
    check({id, "_f0_irw"}, 32'(bus.IRWrite), 0);
    cyc();
    check({id, "_f1_st"}, 32'(state_dbg), 1);
    check({id, "_f1_irw"}, 32'(bus.IRWrite), 1);
    check({id, "_f1_pcw"}, 32'(bus.PC_w), 1);
    check({id, "_f1_srcb"}, 32'(bus.CtrlALUSrcB), 1);
    check({id, "_f1_ula"}, 32'(bus.CtrlULA), 1);
    cyc();
    check({id, "_dec_st"}, 32'(state_dbg), 2);
    check({id, "_dec_abw"}, 32'(bus.ABWrite), 1);
    check({id, "_dec_aow"}, 32'(bus.ALUoutWrite), 1);
    check({id, "_dec_srcb"}, 32'(bus.CtrlALUSrcB), 3);
  endtask

  // entered in EXC_OVF/EXC_OPC, leaves in the following FETCH cycle 0
  task automatic exc_seq(input string id, input logic [4:0] exc_st, input logic [2:0] iord);
    check({id, "_exc_st"}, 32'(state_dbg), 32'(exc_st));
    check({id, "_exc_epc"}, 32'(bus.EPCWrite), 1);
    check({id, "_exc_ula"}, 32'(bus.CtrlULA), 2);
    check({id, "_exc_srcb"}, 32'(bus.CtrlALUSrcB), 1);
    check({id, "_exc_srca"}, 32'(bus.CtrlALUSrcA), 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check({id, "_rd_st"}, 32'(state_dbg), 16);
      check({id, "_rd_iord"}, 32'(bus.CtrlIord), 32'(iord));
      check({id, "_rd_mr"}, 32'(bus.MemRead), 1);
    end
    cyc();
    check({id, "_pc_st"}, 32'(state_dbg), 17);
    check({id, "_pc_pcw"}, 32'(bus.PC_w), 1);
    check({id, "_pc_src"}, 32'(bus.CtrlPCSource), 4);
    cyc();
    check({id, "_back"}, 32'(state_dbg), 1);
  endtask

  initial begin
    reset = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.Of = 1'b0; bus.Eq = 1'b0;
    cyc(); cyc();
    check("rst_st", 32'(state_dbg), 0);
    check("rst_ctl", 32'(ctl_vec), 0);
    reset = 1'b1;
    cyc();

    // R-type add: FETCH x2, DECODE, EXEC_R, WB_R, FETCH
    do_fetch("add");
    cyc();
    check("add_ex_st", 32'(state_dbg), 3);
    check("add_ex_ula", 32'(bus.CtrlULA), 1);
    check("add_ex_srca", 32'(bus.CtrlALUSrcA), 1);
    check("add_ex_srcb", 32'(bus.CtrlALUSrcB), 0);
    check("add_ex_aow", 32'(bus.ALUoutWrite), 1);
    cyc();
    check("add_wb_st", 32'(state_dbg), 4);
    check("add_wb_rw", 32'(bus.RegWrite), 1);
    check("add_wb_dst", 32'(bus.CtrlRegDst), 1);
    check("add_wb_m2r", 32'(bus.CtrlMemtoReg), 0);
    cyc();
    check("add_back", 32'(state_dbg), 1);

    // and with Of=1 still writes back
    bus.funct = 6'h24;
    do_fetch("and");
    bus.Of = 1'b1;
    cyc();
    check("and_ex_ula", 32'(bus.CtrlULA), 3);
    cyc();
    check("and_wb_st", 32'(state_dbg), 4);
    bus.Of = 1'b0;
    cyc();

    // sub with overflow
    bus.funct = 6'h22;
    do_fetch("sub");
    bus.Of = 1'b1;
    cyc();
    check("sub_ex_ula", 32'(bus.CtrlULA), 2);
    cyc();
    bus.Of = 1'b0;
    exc_seq("subovf", 5'd14, 3'd3);

    // addi without and with overflow
    bus.opcode = 6'h08;
    do_fetch("addi");
    cyc();
    check("addi_ex_st", 32'(state_dbg), 5);
    check("addi_ex_srcb", 32'(bus.CtrlALUSrcB), 2);
    cyc();
    check("addi_wb_st", 32'(state_dbg), 6);
    check("addi_wb_rw", 32'(bus.RegWrite), 1);
    check("addi_wb_dst", 32'(bus.CtrlRegDst), 0);
    cyc();
    do_fetch("addio");
    bus.Of = 1'b1;
    cyc();
    check("addio_ex_st", 32'(state_dbg), 5);
    cyc();
    bus.Of = 1'b0;
    exc_seq("addiovf", 5'd14, 3'd3);

    // lw
    bus.opcode = 6'h23;
    do_fetch("lw");
    cyc();
    check("lw_addr_st", 32'(state_dbg), 7);
    check("lw_addr_srcb", 32'(bus.CtrlALUSrcB), 2);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("lw_rd_st", 32'(state_dbg), 9);
      check("lw_rd_iord", 32'(bus.CtrlIord), 1);
      check("lw_rd_mr", 32'(bus.MemRead), 1);
    end
    cyc();
    check("lw_wb_st", 32'(state_dbg), 10);
    check("lw_wb_m2r", 32'(bus.CtrlMemtoReg), 1);
    check("lw_wb_rw", 32'(bus.RegWrite), 1);
    cyc();
    check("lw_back", 32'(state_dbg), 1);

    // sw
    bus.opcode = 6'h2b;
    do_fetch("sw");
    cyc();
    check("sw_addr_st", 32'(state_dbg), 8);
    check("sw_addr_rw", 32'(bus.RegWrite), 0);
    cyc();
    check("sw_wr_st", 32'(state_dbg), 11);
    check("sw_wr_mw", 32'(bus.MemWrite), 1);
    check("sw_wr_iord", 32'(bus.CtrlIord), 1);
    check("sw_wr_rw", 32'(bus.RegWrite), 0);
    cyc();
    check("sw_back", 32'(state_dbg), 1);
    check("sw_back_mw", 32'(bus.MemWrite), 0);

    // beq / bne, with Eq flipped inside BRANCH to exercise the Mealy term
    bus.opcode = 6'h04; bus.Eq = 1'b1;
    do_fetch("beq");
    cyc();
    check("beq_st", 32'(state_dbg), 12);
    check("beq_src", 32'(bus.CtrlPCSource), 1);
    check("beq_ula", 32'(bus.CtrlULA), 7);
    check("beq_eq1_pcw", 32'(bus.PC_w), 1);
    bus.Eq = 1'b0; #1;
    check("beq_eq0_pcw", 32'(bus.PC_w), 0);
    cyc();
    check("beq_back", 32'(state_dbg), 1);
    bus.opcode = 6'h05;
    do_fetch("bne");
    cyc();
    check("bne_eq0_pcw", 32'(bus.PC_w), 1);
    bus.Eq = 1'b1; #1;
    check("bne_eq1_pcw", 32'(bus.PC_w), 0);
    cyc();
    bus.Eq = 1'b0;

    // jump
    bus.opcode = 6'h02;
    do_fetch("j");
    cyc();
    check("j_st", 32'(state_dbg), 13);
    check("j_pcw", 32'(bus.PC_w), 1);
    check("j_src", 32'(bus.CtrlPCSource), 2);
    cyc();

    // invalid opcode and invalid funct
    bus.opcode = 6'h3f;
    do_fetch("badop");
    cyc();
    exc_seq("badop", 5'd15, 3'd2);
    bus.opcode = 6'h00; bus.funct = 6'h21;
    do_fetch("badfn");
    cyc();
    exc_seq("badfn", 5'd15, 3'd2);

    // reset in the middle of EXEC_R
    bus.funct = 6'h20;
    do_fetch("rstmid");
    cyc();
    check("rstmid_ex_st", 32'(state_dbg), 3);
    reset = 1'b0; #1;
    check("rstmid_st", 32'(state_dbg), 0);
    check("rstmid_ctl", 32'(ctl_vec), 0);
    cyc();
    reset = 1'b1;
    cyc();
    check("rstmid_f_st", 32'(state_dbg), 1);
    check("rstmid_f_mr", 32'(bus.MemRead), 1);
    check("rstmid_f_iord", 32'(bus.CtrlIord), 0);

    // break halts until reset
    bus.funct = 6'h0d;
    do_fetch("halt");
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("halt_st", 32'(state_dbg), 18);
      check("halt_ctl", 32'(ctl_vec), 0);
    end
    reset = 1'b0; #1;
    check("halt_rst_st", 32'(state_dbg), 0);
    cyc();
    reset = 1'b1;
    cyc();
    check("halt_rel_st", 32'(state_dbg), 1);
    check("halt_rel_mr", 32'(bus.MemRead), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
